// File: rtl/wash_pkg.sv
// Shared stage codes, default timing and actuator payload for the wash sequencer.
package wash_pkg;

  localparam int unsigned STW = 3;

  // Stage codes double as the Dec output index for the per-stage indicator.
  localparam logic [STW-1:0] ST_IDLE  = 3'd0;
  localparam logic [STW-1:0] ST_FILL  = 3'd1;
  localparam logic [STW-1:0] ST_HEAT  = 3'd2;
  localparam logic [STW-1:0] ST_WASH  = 3'd3;
  localparam logic [STW-1:0] ST_DRAIN = 3'd4;
  localparam logic [STW-1:0] ST_RINSE = 3'd5;
  localparam logic [STW-1:0] ST_SPIN  = 3'd6;
  localparam logic [STW-1:0] ST_DONE  = 3'd7;

  localparam int unsigned DEF_TW         = 8;
  localparam int unsigned DEF_WASH_TIME  = 20;
  localparam int unsigned DEF_RINSE_TIME = 10;
  localparam int unsigned DEF_SPIN_TIME  = 15;

  typedef enum logic [STW-1:0] {
    S_IDLE  = ST_IDLE,
    S_FILL  = ST_FILL,
    S_HEAT  = ST_HEAT,
    S_WASH  = ST_WASH,
    S_DRAIN = ST_DRAIN,
    S_RINSE = ST_RINSE,
    S_SPIN  = ST_SPIN,
    S_DONE  = ST_DONE
  } stage_e;

  typedef struct packed {
    logic valve;
    logic heater;
    logic motor;
    logic pump;
    logic door_lock;
    logic done;
  } act_t;

  // Actuator pattern for a stage; a hold silences actuators but keeps the door locked.
  function automatic act_t stage_outputs(input stage_e st, input logic hold);
    act_t a;
    a = '0;
    case (st)
      S_FILL:  a.valve  = 1'b1;
      S_HEAT:  a.heater = 1'b1;
      S_WASH:  a.motor  = 1'b1;
      S_DRAIN: a.pump   = 1'b1;
      S_RINSE: begin
        a.valve = 1'b1;
        a.motor = 1'b1;
      end
      S_SPIN: begin
        a.motor = 1'b1;
        a.pump  = 1'b1;
      end
      S_DONE:  a.done = 1'b1;
      default: a = '0;
    endcase
    a.door_lock = (st inside {[S_FILL:S_SPIN]});
    if (hold && a.door_lock) begin
      a.valve  = 1'b0;
      a.heater = 1'b0;
      a.motor  = 1'b0;
      a.pump   = 1'b0;
    end
    return a;
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Loadable down-counter timing the WASH, RINSE and SPIN stages.
module stage_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] count_q;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/wash_controller.sv
// Washing-machine programme sequencer: stage FSM, hold handling and registered actuators.
module wash_controller
  import wash_pkg::*;
#(
  parameter int unsigned TW         = DEF_TW,
  parameter int unsigned WASH_TIME  = DEF_WASH_TIME,
  parameter int unsigned RINSE_TIME = DEF_RINSE_TIME,
  parameter int unsigned SPIN_TIME  = DEF_SPIN_TIME
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           door_closed,
  input  logic           pause,
  input  logic           water_full,
  input  logic           temp_ok,
  input  logic           water_empty,
  output logic [STW-1:0] S,
  output logic           valve,
  output logic           heater,
  output logic           motor,
  output logic           pump,
  output logic           door_lock,
  output logic           done
);

  localparam logic [TW-1:0] WASH_LOAD  = TW'(WASH_TIME - 1);
  localparam logic [TW-1:0] RINSE_LOAD = TW'(RINSE_TIME - 1);
  localparam logic [TW-1:0] SPIN_LOAD  = TW'(SPIN_TIME - 1);

  stage_e        state_q, state_d;
  logic          hold_q, hold_d;
  act_t          act_q, act_d;
  logic          t_load, t_en, t_zero;
  logic [TW-1:0] t_val;

  stage_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hold_q  <= 1'b0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      act_q   <= act_d;
    end
  end

  // Next stage and timer control; a registered hold freezes FILL..SPIN.
  always_comb begin
    state_d = state_q;
    hold_d  = pause | ~door_closed;
    t_load  = 1'b0;
    t_val   = '0;
    t_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && door_closed) state_d = S_FILL;
      end
      S_FILL: begin
        if (!hold_q && water_full) state_d = S_HEAT;
      end
      S_HEAT: begin
        if (!hold_q && temp_ok) begin
          state_d = S_WASH;
          t_load  = 1'b1;
          t_val   = WASH_LOAD;
        end
      end
      S_WASH: begin
        if (!hold_q) begin
          if (t_zero) state_d = S_DRAIN;
          else        t_en    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!hold_q && water_empty) begin
          state_d = S_RINSE;
          t_load  = 1'b1;
          t_val   = RINSE_LOAD;
        end
      end
      S_RINSE: begin
        if (!hold_q) begin
          if (t_zero) begin
            state_d = S_SPIN;
            t_load  = 1'b1;
            t_val   = SPIN_LOAD;
          end else begin
            t_en = 1'b1;
          end
        end
      end
      S_SPIN: begin
        if (!hold_q) begin
          if (t_zero) state_d = S_DONE;
          else        t_en    = 1'b1;
        end
      end
      S_DONE: begin
        if (!door_closed) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registering the decode of the next (stage, hold) keeps outputs Moore in the current pair.
    act_d = stage_outputs(state_d, hold_d);
  end

  assign S         = state_q;
  assign valve     = act_q.valve;
  assign heater    = act_q.heater;
  assign motor     = act_q.motor;
  assign pump      = act_q.pump;
  assign door_lock = act_q.door_lock;
  assign done      = act_q.done;

endmodule

// File: tb/tb_wash_controller.sv
// Directed bench for wash_controller with a cycle-level behavioural model.
module tb_wash_controller;

  localparam int W_T = 4;
  localparam int R_T = 3;
  localparam int S_T = 2;

  logic       clk;
  logic       reset;
  logic       start, door_closed, pause, water_full, temp_ok, water_empty;
  logic [2:0] S;
  logic       valve, heater, motor, pump, door_lock, done;

  int vectors = 0;
  int miscompares = 0;

  wash_controller #(
    .TW(8), .WASH_TIME(W_T), .RINSE_TIME(R_T), .SPIN_TIME(S_T)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .door_closed(door_closed),
    .pause(pause), .water_full(water_full), .temp_ok(temp_ok),
    .water_empty(water_empty), .S(S), .valve(valve), .heater(heater),
    .motor(motor), .pump(pump), .door_lock(door_lock), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: stage number, cycles left in a timed stage, and the one-cycle-late hold.
  int m_stage = 0;
  int m_rem   = 0;
  bit m_hold  = 1'b0;

  function automatic int exp_bundle(input int st, input bit hold);
    bit v, h, m, p, lk, d;
    v  = (st == 1) || (st == 5);
    h  = (st == 2);
    m  = (st == 3) || (st == 5) || (st == 6);
    p  = (st == 4) || (st == 6);
    lk = (st >= 1) && (st <= 6);
    d  = (st == 7);
    if (lk && hold) begin
      v = 0; h = 0; m = 0; p = 0;
    end
    return {st[2:0], v, h, m, p, lk, d};
  endfunction

  task automatic model_step();
    bit nh;
    nh = pause | ~door_closed;
    if (m_stage == 0) begin
      if (start && door_closed) m_stage = 1;
    end else if (m_stage == 7) begin
      if (!door_closed) m_stage = 0;
    end else if (!m_hold) begin
      case (m_stage)
        1: if (water_full) m_stage = 2;
        2: if (temp_ok) begin m_stage = 3; m_rem = W_T; end
        4: if (water_empty) begin m_stage = 5; m_rem = R_T; end
        3, 5, 6: begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            if (m_stage == 5) m_rem = S_T;
            m_stage = m_stage + 1;
          end
        end
        default: ;
      endcase
    end
    m_hold = nh;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_stage = 0; m_rem = 0; m_hold = 1'b0;
    end else begin
      model_step();
    end
    #1;
    chk("cycle", int'({S, valve, heater, motor, pump, door_lock, done}),
        exp_bundle(m_stage, m_hold));
  end

  int seq_q[$];
  int stage_len[8];
  int held_wash, held_rinse;

  task automatic do_reset();
    @(negedge clk);
    reset = 0; start = 0; pause = 0; door_closed = 1;
    water_full = 0; temp_ok = 0; water_empty = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  // Drives one programme from IDLE, reacting to the visible stage; stops on reaching stop_st.
  task automatic run_prog(input int pw_at, input int pw_len, input int dr_at,
                          input int dr_len, input int drain_wait, input int stop_st);
    int s, prev, cnt, guard;
    prev = -1; cnt = 0; guard = 0;
    seq_q.delete();
    for (int i = 0; i < 8; i++) stage_len[i] = 0;
    held_wash = 0; held_rinse = 0;
    start = 1; door_closed = 1;
    forever begin
      s = int'(S);
      if (s == prev) cnt++; else cnt = 1;
      prev = s;
      seq_q.push_back(s);
      stage_len[s]++;
      if (s == 3 && !motor && door_lock) held_wash++;
      if (s == 5 && !valve && !motor && door_lock) held_rinse++;
      if (s == stop_st) break;
      if (++guard > 200) begin
        vectors++; miscompares++;
        $display("FAIL prog_timeout: stuck in stage %0d, expected stage %0d", s, stop_st);
        break;
      end
      water_full  = (s == 1) || (s == 4);
      temp_ok     = (s == 2);
      water_empty = (s == 4) && (cnt > drain_wait);
      pause       = (s == 3) && (cnt > pw_at) && (cnt <= pw_at + pw_len);
      door_closed = !((s == 5) && (cnt > dr_at) && (cnt <= dr_at + dr_len));
      @(negedge clk);
    end
  endtask

  int exp_seq[14];

  initial begin
    exp_seq = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 5, 5, 6, 6, 7};
    reset = 0; start = 0; door_closed = 1; pause = 0;
    water_full = 0; temp_ok = 0; water_empty = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({S, valve, heater, motor, pump, door_lock, done}), 0);
    reset = 1;
    @(negedge clk);

    // Full programme, restart after DONE.
    run_prog(100, 0, 100, 0, 0, 7);
    chk("seq_len", seq_q.size(), 14);
    for (int i = 0; i < 14 && i < seq_q.size(); i++) chk("stage_seq", seq_q[i], exp_seq[i]);
    chk("done_in_7", int'({done, door_lock}), 2);
    door_closed = 0;
    @(negedge clk);
    chk("door_open_idle", int'(S), 0);
    door_closed = 1;
    @(negedge clk);
    chk("restart_fill", int'(S), 1);
    do_reset();

    // Start gated by an open door.
    door_closed = 0; start = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("start_gated", int'({S, door_lock}), 0);
    end
    do_reset();

    // Pause in WASH; water_full held during DRAIN must not advance it.
    run_prog(2, 3, 100, 0, 2, 7);
    chk("wash_len", stage_len[3], 7);
    chk("wash_held", held_wash, 3);
    chk("drain_len", stage_len[4], 3);
    do_reset();

    // Door opened during RINSE.
    run_prog(100, 0, 1, 2, 0, 7);
    chk("rinse_len", stage_len[5], 5);
    chk("rinse_held", held_rinse, 2);
    chk("spin_len", stage_len[6], 2);
    do_reset();

    // Asynchronous reset mid-SPIN.
    run_prog(100, 0, 100, 0, 0, 6);
    #2;
    reset = 0;
    #1;
    chk("async_reset", int'({S, valve, heater, motor, pump, door_lock, done}), 0);
    @(negedge clk);
    reset = 1; start = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
